// File: rtl/lift_call_queue.sv
// Hall-call capture and FIFO feeding the lift controller FSM.
// Optional statistics outputs are enabled by defining LIFT_QUEUE_STATS_EN.
module lift_call_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [5:0]    call_btn,
  input  logic          done,
  output logic [2:0]    req_code,
  output logic          q_empty,
  output logic [5:0]    pending,
`ifdef LIFT_QUEUE_STATS_EN
  output logic [15:0]   served_cnt,
  output logic [CW-1:0] max_occ,
`endif
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  function automatic logic [2:0] bit2code(input logic [5:0] oh);
    logic [2:0] c;
    c = 3'b000;
    unique case (1'b1)
      oh[0]: c = 3'b001;
      oh[1]: c = 3'b010;
      oh[2]: c = 3'b011;
      oh[3]: c = 3'b110;
      oh[4]: c = 3'b111;
      oh[5]: c = 3'b100;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

  function automatic logic [5:0] code2bit(input logic [2:0] c);
    logic [5:0] oh;
    oh = 6'b0;
    case (c)
      3'b001: oh = 6'b000001;
      3'b010: oh = 6'b000010;
      3'b011: oh = 6'b000100;
      3'b110: oh = 6'b001000;
      3'b111: oh = 6'b010000;
      3'b100: oh = 6'b100000;
      default: oh = 6'b000000;
    endcase
    return oh;
  endfunction

  logic [5:0]    btn_q;
  logic [5:0]    cap;
  logic [5:0]    inq;
  logic [2:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic          pop;
  logic          push;
  logic [2:0]    head;
  logic [5:0]    rise;
  logic [5:0]    sel_oh;
  logic [5:0]    push_oh;
  logic [5:0]    pop_oh;
  logic [5:0]    cap_n;
  logic [5:0]    inq_n;
  logic [CW-1:0] count_n;

  always_comb begin
    head    = mem[rd_ptr];
    pop     = done && (count != '0);
    pop_oh  = pop ? code2bit(head) : 6'b0;
    rise    = call_btn & ~btn_q;
    sel_oh  = cap & (~cap + 6'd1);
    push    = (cap != 6'b0) && ((count < FULL) || pop);
    push_oh = push ? sel_oh : 6'b0;
    // A rise on the code being served this cycle is absorbed by the move.
    cap_n   = (cap & ~push_oh) | (rise & ~pending & ~pop_oh);
    inq_n   = (inq & ~pop_oh) | push_oh;
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  // Loads during reset too, so a held button cannot create a request.
  always_ff @(posedge clk) begin
    btn_q <= call_btn;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bit2code(sel_oh);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap    <= 6'b0;
      inq    <= 6'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      cap   <= cap_n;
      inq   <= inq_n;
      count <= count_n;
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
    end
  end

`ifdef LIFT_QUEUE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      served_cnt <= 16'h0;
      max_occ    <= '0;
    end else begin
      if (pop && served_cnt != 16'hFFFF) served_cnt <= served_cnt + 16'h1;
      if (count_n > max_occ) max_occ <= count_n;
    end
  end
`endif

  assign req_code = (count != '0) ? head : 3'b000;
  assign q_empty  = (count == '0);
  assign pending  = cap | inq;

endmodule

// File: doc/lift_call_queue.md
Name: lift_call_queue

Overview:
- Upstream stage of the lift controller FSM.
- Converts the six raw hall-call button levels into deduplicated request codes.
- Buffers the requests in arrival order in a FIFO and presents the head code plus an empty flag to the FSM's request input and queue-empty input.
- Pops the head when the FSM reports it is idle (done) and consumes the request.

Parameters:
DEPTH, 4, FIFO entries; legal 2..8. Values below 6 allow backpressure into the capture register.
CW, $clog2(DEPTH+1), width of the count output.

Ports:
clk  in  1  single clock; all logic on posedge
rst  in  1  reset, synchronous, active-high
call_btn  in  6  raw button levels: bit0=1U, bit1=2U, bit2=3U, bit3=2D, bit4=3D, bit5=4D
done  in  1  FSM idle flag; a pop occurs when done=1 and q_empty=0
req_code  out  3  head request code to the FSM; 3'b000 when empty
q_empty  out  1  1 when the FIFO holds no entries
pending  out  6  per-button lamp: call captured or queued, not yet served
count  out  CW  FIFO occupancy

Behaviour:
- Code map (bit index -> code): 0->001, 1->010, 2->011, 3->110, 4->111, 5->100. The FIFO stores only these six codes.
- Edge detect: btn_q <= call_btn every cycle. rise = call_btn & ~btn_q.
- During rst, btn_q loads call_btn, so a button held through reset produces no request.
- Capture register cap[5:0]: cap[i] is set on rise[i] unless pending[i]=1, in which case the duplicate is ignored.
- Queued mask inq[5:0]: set on push, cleared on pop of that code. pending = cap | inq.
- Push: each cycle, the lowest-index set cap bit is selected. If count<DEPTH, or a pop occurs in the same cycle, that code is written at the tail, its cap bit clears and its inq bit sets. Otherwise the cap bit holds (backpressure, no loss). At most one push per cycle.
- Pop: when done && !q_empty, the head advances, count decrements and the head code's inq bit clears.
- Push and pop in the same cycle: count is unchanged, and a push into a full FIFO is allowed.
- Rise on a button whose code is being popped in the same cycle is ignored; that call counts as served by the current move.
- Latency: a button first sampled high at edge N sets cap after N, pushes at N+1, so q_empty=0 and req_code is valid after N+1. This holds when the FIFO is not full and no lower-index cap bit is set.
- req_code = head entry when count>0, else 3'b000. q_empty = (count==0). Both are registered-state derived with no combinational path from call_btn or done.
- Pointers are log2(DEPTH)-bit (or modulo DEPTH when DEPTH is not a power of two) and wrap from DEPTH-1 to 0.
- Reset values: cap=0, inq=0, pointers=0, count=0, q_empty=1, req_code=000, pending=0.
- Reset asserted mid-operation discards all captured and queued calls on that edge.
- Invariants: count <= DEPTH. popcount(inq) == count. cap & inq == 0.

Optional Feature:
LIFT_QUEUE_STATS_EN:
- Defined: adds output served_cnt[15:0], which increments on each pop and saturates at 16'hFFFF. Adds output max_occ[CW-1:0], the highest count reached since reset. Both clear on rst.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Reset with call_btn=6'b000100 held, release rst, keep it held for 10 cycles -> q_empty stays 1 and pending=0.
- done=0; press bit2 (3U) at edge N -> pending[2]=1 after N; after N+1 count=1, req_code=011, q_empty=0. Raise done for one cycle -> count=0, req_code=000, pending[2]=0.
- done=0; press bits 0,3,5 simultaneously -> pushes occur in order 001, 110, 100 on three consecutive cycles. Then pop three times -> req_code sequence is 001, 110, 100.
- DEPTH=4, done=0; press all six buttons -> count=4 and cap holds 111,100. Pop once -> on that same cycle 111 is pushed and count stays 4. The next pop lets 100 in; no request is lost.
- Press 2D twice while queued -> count=1 with no duplicate. Press 2D on the exact cycle it is popped -> ignored, and count stays 0 afterwards.
- With LIFT_QUEUE_STATS_EN: 3 presses and 3 pops -> served_cnt=3, max_occ=3. Assert rst mid-queue -> all outputs return to reset values.
